// File: rtl/inst_fetch_rom.sv
// inst_fetch_rom: instruction-memory read stage sitting right after the PC.
// Reads the ROM synchronously from the incoming PC and registers the word,
// its PC tag and a valid flag for decode. It also flags halt and out-of-range
// fetches, and accepts writes through a load port.
// Optional feature macro: FETCH_PARITY_EN. It adds a stored even-parity bit
// per word and a sticky parity_err output.
module inst_fetch_rom #(
   parameter int unsigned         PC_W    = 16,
   parameter int unsigned         ADDR_W  = 10,
   parameter int unsigned         INSTR_W = 9,
   parameter logic [INSTR_W-1:0]  HALT_OP = 9'h1FF,
   parameter logic [INSTR_W-1:0]  NOP_OP  = 9'h000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [PC_W-1:0]     pc,
   input  logic                stall,
   input  logic                flush,
   input  logic                load_en,
   input  logic [ADDR_W-1:0]   load_addr,
   input  logic [INSTR_W-1:0]  load_data,
   output logic [INSTR_W-1:0]  instr,
   output logic [PC_W-1:0]     instr_pc,
   output logic                instr_valid,
   output logic                halt_req,
   output logic                pc_oob,
`ifdef FETCH_PARITY_EN
   output logic                parity_err,
`endif
   output logic [15:0]         instr_count
);

`ifdef FETCH_PARITY_EN
   localparam int unsigned WORD_W = INSTR_W + 1;
`else
   localparam int unsigned WORD_W = INSTR_W;
`endif

   typedef enum logic [1:0] {
      ST_FILL = 2'd0,
      ST_RUN  = 2'd1,
      ST_STOP = 2'd2
   } state_t;

   // Memory contents survive reset, so the array has no reset branch.
   logic [WORD_W-1:0]  rom_mem [2**ADDR_W];

   logic [WORD_W-1:0]  wr_word;
   logic [WORD_W-1:0]  rd_word;
   logic [INSTR_W-1:0] rd_instr;
   logic [ADDR_W-1:0]  rd_addr;
   logic               pc_in_range;
`ifdef FETCH_PARITY_EN
   logic               rd_parity_ok;
   logic               parity_err_q, parity_err_d;
`endif

   state_t             state_q, state_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [PC_W-1:0]    instr_pc_q, instr_pc_d;
   logic               valid_q, valid_d;
   logic               halt_q, halt_d;
   logic               oob_q, oob_d;
   logic [15:0]        count_q, count_d;
   logic [15:0]        count_inc;

   // Word written by the load port; the parity bit makes the stored word XOR to 0.
   always_comb begin
`ifdef FETCH_PARITY_EN
      wr_word = {^load_data, load_data};
`else
      wr_word = load_data;
`endif
   end

   // Load-port write. It lands even while stalled or stopped, because
   // memory contents are not part of the held pipeline state.
   always_ff @(posedge clk) begin
      if (load_en) begin
         rom_mem[load_addr] <= wr_word;
      end
   end

   // Read path with write-first bypass and range/parity decode.
   always_comb begin
      rd_addr     = pc[ADDR_W-1:0];
      pc_in_range = ((pc >> ADDR_W) == '0);
      if (load_en && (load_addr == rd_addr)) begin
         rd_word = wr_word;
      end else begin
         rd_word = rom_mem[rd_addr];
      end
      rd_instr = rd_word[INSTR_W-1:0];
`ifdef FETCH_PARITY_EN
      rd_parity_ok = ~(^rd_word);
`endif
   end

   // Next-state and next-output logic for the fetch control FSM.
   always_comb begin
      state_d    = state_q;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
      valid_d    = valid_q;
      halt_d     = halt_q;
      oob_d      = oob_q;
      count_d    = count_q;
`ifdef FETCH_PARITY_EN
      parity_err_d = parity_err_q;
`endif
      count_inc  = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;

      if (!stall) begin
         unique case (state_q)
            ST_FILL: begin
               // Bubble cycle; loads keep us here so the memory can be filled.
               instr_d    = NOP_OP;
               instr_pc_d = pc;
               valid_d    = 1'b0;
               if (!load_en) begin
                  state_d = ST_RUN;
               end
            end
            ST_RUN: begin
               instr_pc_d = pc;
               if (load_en) begin
                  // Word is visible (write-first) but not issued.
                  instr_d = pc_in_range ? rd_instr : NOP_OP;
                  valid_d = 1'b0;
               end else if (flush) begin
                  instr_d = NOP_OP;
                  valid_d = 1'b0;
               end else if (!pc_in_range) begin
                  instr_d = NOP_OP;
                  valid_d = 1'b1;
                  oob_d   = 1'b1;
                  count_d = count_inc;
`ifdef FETCH_PARITY_EN
               end else if (!rd_parity_ok) begin
                  instr_d      = NOP_OP;
                  valid_d      = 1'b0;
                  parity_err_d = 1'b1;
                  state_d      = ST_STOP;
`endif
               end else begin
                  instr_d = rd_instr;
                  valid_d = 1'b1;
                  count_d = count_inc;
                  if (rd_instr == HALT_OP) begin
                     halt_d  = 1'b1;
                     state_d = ST_STOP;
                  end
               end
            end
            ST_STOP: begin
               // instr and instr_pc stay frozen until reset.
               valid_d = 1'b0;
            end
            default: begin
               state_d = ST_FILL;
               valid_d = 1'b0;
            end
         endcase
      end
   end

   // Single register bank for FSM state and all registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_FILL;
         instr_q    <= NOP_OP;
         instr_pc_q <= '0;
         valid_q    <= 1'b0;
         halt_q     <= 1'b0;
         oob_q      <= 1'b0;
         count_q    <= '0;
`ifdef FETCH_PARITY_EN
         parity_err_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         instr_q    <= instr_d;
         instr_pc_q <= instr_pc_d;
         valid_q    <= valid_d;
         halt_q     <= halt_d;
         oob_q      <= oob_d;
         count_q    <= count_d;
`ifdef FETCH_PARITY_EN
         parity_err_q <= parity_err_d;
`endif
      end
   end

   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
   assign instr_valid = valid_q;
   assign halt_req    = halt_q;
   assign pc_oob      = oob_q;
   assign instr_count = count_q;
`ifdef FETCH_PARITY_EN
   assign parity_err  = parity_err_q;
`endif

endmodule

// File: tb/tb_inst_fetch_rom.sv
// tb_inst_fetch_rom: directed bench for inst_fetch_rom with a behavioural
// model checked every cycle plus literal spot checks.
`timescale 1ns/1ps
module tb_inst_fetch_rom;
   localparam logic [8:0] HALT = 9'h1FF;
   localparam logic [8:0] NOP  = 9'h000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] pc = '0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        load_en = 1'b0;
   logic [9:0]  load_addr = '0;
   logic [8:0]  load_data = '0;
   logic [8:0]  instr;
   logic [15:0] instr_pc;
   logic        instr_valid;
   logic        halt_req;
   logic        pc_oob;
   logic [15:0] instr_count;
`ifdef FETCH_PARITY_EN
   logic        parity_err;
`endif

   inst_fetch_rom dut (
      .clk(clk), .reset(reset), .pc(pc), .stall(stall), .flush(flush),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
      .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
      .halt_req(halt_req), .pc_oob(pc_oob),
`ifdef FETCH_PARITY_EN
      .parity_err(parity_err),
`endif
      .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: memory image, corrupted-word marks, and expected outputs.
   logic [8:0]  shadow [1024];
   bit          bad_par [1024];
   bit          m_fresh, m_stop, m_valid, m_halt, m_oob, m_perr;
   logic [8:0]  m_instr;
   logic [15:0] m_pc;
   int          m_count;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // What the stage must present after this edge, from the behavioural rules.
   task automatic model_step();
      if (reset) begin
         m_fresh = 1; m_stop = 0; m_valid = 0; m_halt = 0; m_oob = 0; m_perr = 0;
         m_instr = NOP; m_pc = 0; m_count = 0;
      end else begin
         if (load_en) begin
            shadow[load_addr]  = load_data;
            bad_par[load_addr] = 0;
         end
         if (stall) begin
            // everything held
         end else if (m_stop) begin
            m_valid = 0;
         end else if (m_fresh) begin
            m_valid = 0;
            if (!load_en) m_fresh = 0;
         end else begin
            m_pc = pc;
            if (load_en) begin
               m_valid = 0;
            end else if (flush) begin
               m_valid = 0; m_instr = NOP;
            end else if (pc >= 16'd1024) begin
               m_valid = 1; m_instr = NOP; m_oob = 1;
               if (m_count < 65535) m_count++;
            end else if (bad_par[pc[9:0]]) begin
               m_valid = 0; m_instr = NOP; m_perr = 1; m_stop = 1;
            end else begin
               m_valid = 1; m_instr = shadow[pc[9:0]];
               if (m_count < 65535) m_count++;
               if (m_instr == HALT) begin m_halt = 1; m_stop = 1; end
            end
         end
      end
   endtask

   task automatic cyc(input logic r, input logic [15:0] p, input logic st, input logic fl,
                      input logic le, input logic [9:0] la, input logic [8:0] ld);
      reset = r; pc = p; stall = st; flush = fl;
      load_en = le; load_addr = la; load_data = ld;
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic idle(input logic [15:0] p);
      cyc(1'b0, p, 1'b0, 1'b0, 1'b0, 10'd0, 9'd0);
   endtask

   task automatic ld(input logic [9:0] a, input logic [8:0] d);
      cyc(1'b0, 16'd0, 1'b0, 1'b0, 1'b1, a, d);
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      check("valid", instr_valid, m_valid);
      check("halt_req", halt_req, m_halt);
      check("pc_oob", pc_oob, m_oob);
      check("count", instr_count, m_count);
      if (m_valid || m_stop) begin
         check("instr", instr, m_instr);
         check("instr_pc", instr_pc, m_pc);
      end
`ifdef FETCH_PARITY_EN
      check("parity_err", parity_err, m_perr);
`endif
   end

   initial begin
      cyc(1'b1, 16'd0, 1'b0, 1'b0, 1'b0, 10'd0, 9'd0);
      cyc(1'b1, 16'd0, 1'b0, 1'b0, 1'b0, 10'd0, 9'd0);
      check("lit_reset_instr", instr, NOP);
      check("lit_reset_count", instr_count, 0);

      // Fill the memory while held in FILL
      ld(0, 9'h011); ld(1, 9'h022); ld(2, 9'h033); ld(3, 9'h044);
      ld(4, 9'h088); ld(5, HALT);   ld(6, 9'h099); ld(7, 9'h055);
      ld(8, 9'h066); ld(9, 9'h077);
      check("lit_fill_hold_valid", instr_valid, 0);

      // Reset again: memory retained
      cyc(1'b1, 16'd0, 1'b0, 1'b0, 1'b0, 10'd0, 9'd0);
      idle(0);
      check("lit_fill_bubble", instr_valid, 0);
      idle(0);
      check("lit_f0_instr", instr, 9'h011);
      check("lit_f0_valid", instr_valid, 1);
      idle(1);
      check("lit_f1_instr", instr, 9'h022);
      idle(2);
      check("lit_f2_instr", instr, 9'h033);
      idle(3);
      check("lit_f3_instr", instr, 9'h044);
      check("lit_f3_pc", instr_pc, 3);
      check("lit_f3_count", instr_count, 4);

      // Flush
      cyc(1'b0, 16'd2, 1'b0, 1'b1, 1'b0, 10'd0, 9'd0);
      check("lit_flush_valid", instr_valid, 0);
      check("lit_flush_instr", instr, NOP);
      check("lit_flush_pc", instr_pc, 2);
      check("lit_flush_count", instr_count, 4);
      idle(3);
      check("lit_resume_valid", instr_valid, 1);
      check("lit_resume_count", instr_count, 5);

      // Out-of-range PC
      idle(16'h0400);
      check("lit_oob_instr", instr, NOP);
      check("lit_oob_valid", instr_valid, 1);
      check("lit_oob_flag", pc_oob, 1);
      idle(0);
      check("lit_oob_sticky", pc_oob, 1);
      check("lit_oob_count", instr_count, 7);

      // Load while fetching same address, then stall (one with flush)
      cyc(1'b0, 16'd7, 1'b0, 1'b0, 1'b1, 10'd7, 9'h0AB);
      check("lit_load_valid", instr_valid, 0);
      cyc(1'b0, 16'd1, 1'b1, 1'b0, 1'b0, 10'd0, 9'd0);
      cyc(1'b0, 16'd2, 1'b1, 1'b1, 1'b0, 10'd0, 9'd0);
      cyc(1'b0, 16'd3, 1'b1, 1'b0, 1'b0, 10'd0, 9'd0);
      check("lit_stall_count", instr_count, 7);
      check("lit_stall_valid", instr_valid, 0);
      idle(7);
      check("lit_reload_instr", instr, 9'h0AB);
      check("lit_reload_count", instr_count, 8);

      // Walk a few addresses
      idle(4); idle(6); idle(8); idle(9); idle(1);

      // Halt word on a flushed cycle, then under a load: no halt
      cyc(1'b0, 16'd5, 1'b0, 1'b1, 1'b0, 10'd0, 9'd0);
      check("lit_flushed_halt", halt_req, 0);
      cyc(1'b0, 16'd5, 1'b0, 1'b0, 1'b1, 10'd10, 9'h123);
      check("lit_loaded_halt", halt_req, 0);

      // Real halt
      idle(5);
      check("lit_halt_req", halt_req, 1);
      check("lit_halt_instr", instr, HALT);
      check("lit_halt_valid", instr_valid, 1);
      check("lit_halt_count", instr_count, 14);
      for (int i = 0; i < 10; i++) idle(16'(i));
      check("lit_stop_instr", instr, HALT);
      check("lit_stop_pc", instr_pc, 5);
      check("lit_stop_valid", instr_valid, 0);
      check("lit_stop_count", instr_count, 14);

      // Reset out of STOP
      cyc(1'b1, 16'd0, 1'b0, 1'b0, 1'b0, 10'd0, 9'd0);
      check("lit_rst2_halt", halt_req, 0);
      check("lit_rst2_oob", pc_oob, 0);
      check("lit_rst2_count", instr_count, 0);
      idle(0);
      idle(1);
      check("lit_rst2_instr", instr, 9'h022);
      check("lit_rst2_cnt1", instr_count, 1);

`ifdef FETCH_PARITY_EN
      // Corrupt stored parity of word 9 through the hierarchy
      dut.rom_mem[9] = dut.rom_mem[9] ^ 10'h200;
      bad_par[9] = 1;
      idle(9);
      check("lit_par_err", parity_err, 1);
      check("lit_par_instr", instr, NOP);
      check("lit_par_valid", instr_valid, 0);
      idle(0);
      check("lit_par_stop", instr_valid, 0);
`endif

      idle(0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/inst_fetch_rom.md
Name: inst_fetch_rom

Overview:
- Instruction-memory read stage directly downstream of the program counter.
- Takes the 16-bit PC each cycle and does a synchronous read of the instruction ROM.
- Presents a registered instruction word, with its PC and a valid flag, to decode.
- Detects the halt opcode and out-of-range PCs; back-fills the memory through a load port used by the bench and boot logic.

Parameters:
- PC_W, 16, width of incoming PC and registered PC tag
- ADDR_W, 10, ROM address width; depth = 2**ADDR_W words
- INSTR_W, 9, instruction word width
- HALT_OP, 9'h1FF, opcode that requests halt
- NOP_OP, 9'h000, word substituted on bubble/flush/out-of-range

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- pc  input  PC_W  current program counter (core value from PC stage)
- stall  input  1  hold all outputs and counters this cycle
- flush  input  1  taken branch; discard the instruction fetched this cycle
- load_en  input  1  write load_data to ROM[load_addr] this cycle
- load_addr  input  ADDR_W  load port address
- load_data  input  INSTR_W  load port data
- instr  output  INSTR_W  registered instruction
- instr_pc  output  PC_W  PC that produced instr
- instr_valid  output  1  instr is real, not a bubble
- halt_req  output  1  sticky; HALT_OP has issued
- pc_oob  output  1  sticky; a PC >= 2**ADDR_W was fetched
- instr_count  output  16  number of valid instructions issued

Behaviour:
- All state updates on posedge clk. Synchronous reset, active-high, with priority over everything.
- Reset values: instr=NOP_OP, instr_pc=0, instr_valid=0, halt_req=0, pc_oob=0, instr_count=0, FSM=FILL. ROM contents are not cleared by reset.
- FSM states:
  - FILL: one bubble cycle after reset. Outputs instr_valid=0. Goes to RUN next cycle unless load_en=1, in which case it stays in FILL.
  - RUN: normal fetch. Goes to STOP the cycle a HALT_OP word is registered.
  - STOP: instr and instr_pc frozen, instr_valid=0. Left only by reset.
- Fetch latency is 1 cycle: the pc value sampled at edge N appears on instr/instr_pc after edge N, with instr_valid=1.
- Out-of-range PC: any pc bit at or above ADDR_W set means instr=NOP_OP, instr_valid=1, and pc_oob is set sticky. Address wrap-around is never used.
- flush=1 in RUN: the next registered word is NOP_OP, instr_pc=pc, instr_valid=0, and instr_count is unchanged.
- stall=1: all outputs and the FSM hold. stall has priority over flush. A flush during stall is dropped; the PC stage re-asserts it.
- load_en=1:
  - The write lands at the edge.
  - A read of the same address in the same cycle returns the new data (write-first).
  - In RUN, load_en also forces instr_valid=0 that cycle, with no count increment.
- halt_req is set on the edge that registers HALT_OP with instr_valid=1. That instruction is itself valid and counted. Thereafter STOP.
- instr_count increments by 1 on each edge where the new instr_valid=1. It saturates at 16'hFFFF with no wrap.
- Simultaneous events: reset over stall over load_en over flush over normal fetch. A halt word arriving on a flushed cycle is discarded and does not set halt_req.
- Reset mid-operation (any state) returns to FILL next cycle; ROM is retained.

Optional Feature:
- Macro: FETCH_PARITY_EN.
- Defined:
  - Each ROM word stores an extra even-parity bit computed from load_data at write.
  - On read, parity is rechecked. A mismatch on a valid fetch sets a new output parity_err (1 bit, sticky, reset 0), forces instr=NOP_OP, and moves the FSM to STOP.
- Undefined:
  - No parity storage and no parity_err port.
  - Behaviour is otherwise identical.

Test Plan:
- Reset release with ROM[0..3]=9'h011,9'h022,9'h033,9'h044 and pc stepping 0,1,2,3 -> cycle 1 instr_valid=0 (FILL); then instr=011,022,033,044 with instr_pc=0..3, instr_count=4.
- pc=2 with flush=1 for one cycle in RUN -> next instr=NOP_OP, instr_valid=0, instr_pc=2, instr_count unchanged; following cycle resumes valid.
- ROM[5]=HALT_OP, pc=5 -> halt_req=1, instr=1FF valid and counted; then instr_valid stays 0 and outputs frozen for 10 further cycles despite pc changes, until reset -> FILL.
- pc=16'h0400 (ADDR_W=10) -> instr=NOP_OP, instr_valid=1, pc_oob=1; pc_oob stays 1 after pc returns to 0.
- load_en=1, load_addr=7, load_data=9'h0AB while pc=7, then stall=1 for 3 cycles -> ROM[7]=0AB; outputs, count and FSM held during stall; the next fetch of pc=7 returns 0AB.
- With FETCH_PARITY_EN, corrupt the stored parity of ROM[9] via backdoor, pc=9 -> parity_err=1, instr=NOP_OP, FSM=STOP.
